// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, ALU op codes, mux encodings and FSM state enum
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  // Which ALU-op rule applies in the current state
  typedef enum logic [1:0] {
    CLS_DEFAULT, CLS_REXEC, CLS_IEXEC, CLS_BRANCH
  } alu_class_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - maps (state class, opcode, funct) to alu_ctrl, ext_zero and funct legality
module alu_op_decode
  import mips_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_ctrl,
  output logic        ext_zero,
  output logic        funct_legal
);

  always_comb begin
    funct_legal = 1'b1;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
      default:                               funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    ext_zero = 1'b0;
    case (cls)
      CLS_REXEC: begin
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      // Logical immediates are zero-extended; addi keeps sign extension
      CLS_IEXEC: begin
        case (opcode)
          OP_ANDI: begin alu_ctrl = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin alu_ctrl = ALU_OR;  ext_zero = 1'b1; end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      CLS_BRANCH: alu_ctrl = ALU_SUB;
      default:    alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control FSM; MIPS_MC_MEM_WAIT_EN adds mem_ready wait states
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t     state_q, state_d;
  alu_class_t cls;
  logic       funct_legal;
  logic       mem_ok;
  logic       pc_write;
  logic       branch;
  logic [3:0] dec_alu;
  logic       dec_ext;

`ifdef MIPS_MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    cls = CLS_DEFAULT;
    case (state_q)
      S_R_EXEC:         cls = CLS_REXEC;
      S_I_EXEC, S_I_WB: cls = CLS_IEXEC;
      S_BRANCH:         cls = CLS_BRANCH;
      default:          cls = CLS_DEFAULT;
    endcase
  end

  alu_op_decode u_alu_op_decode (
    .cls         (cls),
    .opcode      (opcode),
    .funct       (funct),
    .alu_ctrl    (dec_alu),
    .ext_zero    (dec_ext),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Outputs stay at their idle defaults while rst_n is low, even though state is FETCH
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_zero   = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      alu_ctrl = dec_alu;
      ext_zero = dec_ext;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ok;
          pc_write  = mem_ok;
          if (mem_ok) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          case (opcode)
            OP_LW, OP_SW:              state_d = S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_I_EXEC;
            OP_BEQ:                    state_d = S_BRANCH;
            OP_J:                      state_d = S_JUMP;
            OP_RTYPE: begin
              if (funct_legal) state_d = S_R_EXEC;
              else begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
              end
            end
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ok) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ok;
          if (mem_ok) state_d = S_FETCH;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = S_I_WB;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          branch     = 1'b1;
          pc_src     = PCSRC_ALUOUT;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - scoreboard bench for mips_mc_ctrl; wait-state steps run when MIPS_MC_MEM_WAIT_EN is defined
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_ctrl;

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_src(pc_src),
    .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam int ST_RST = 0, ST_F = 1, ST_D = 2, ST_MA = 3, ST_MR = 4, ST_MWB = 5, ST_MWR = 6;
  localparam int ST_RE = 7, ST_RW = 8, ST_IE = 9, ST_IW = 10, ST_BR = 11, ST_JP = 12;

  function automatic logic legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h02: return 1'b1;
      6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
      default: return 1'b0;
    endcase
  endfunction

  // Expected output vector for one state, written straight from the control table
  function automatic logic [19:0] expv(int st, logic [5:0] op, logic [5:0] fn, logic z, logic rdy);
    logic       pcw, br, io, mr, mw, irw, rd, m2r, rw, sa, ez, done, ill;
    logic [1:0] sb, ps;
    logic [3:0] alu;
    {pcw, br, io, mr, mw, irw, rd, m2r, rw, sa, ez, done, ill} = '0;
    sb  = 2'b00;
    ps  = 2'b00;
    alu = 4'b0010;
    case (st)
      ST_F:   begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      ST_D:   begin sb = 2'b11; ill = ~legal(op, fn); done = ill; end
      ST_MA:  begin sa = 1'b1; sb = 2'b10; end
      ST_MR:  begin io = 1'b1; mr = 1'b1; end
      ST_MWB: begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
      ST_MWR: begin io = 1'b1; mw = 1'b1; done = 1'b1; end
      ST_RE: begin
        sa = 1'b1;
        case (fn)
          6'h22:   alu = 4'b0110;
          6'h24:   alu = 4'b0000;
          6'h25:   alu = 4'b0001;
          6'h2A:   alu = 4'b0111;
          default: alu = 4'b0010;
        endcase
      end
      ST_RW:  begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
      ST_IE, ST_IW: begin
        if (st == ST_IE) begin sa = 1'b1; sb = 2'b10; end
        else begin rw = 1'b1; done = 1'b1; end
        if (op == 6'h0C) begin alu = 4'b0000; ez = 1'b1; end
        else if (op == 6'h0D) begin alu = 4'b0001; ez = 1'b1; end
      end
      ST_BR:  begin sa = 1'b1; br = 1'b1; ps = 2'b01; alu = 4'b0110; done = 1'b1; end
      ST_JP:  begin pcw = 1'b1; ps = 2'b10; done = 1'b1; end
      default: ;
    endcase
    return {pcw | (br & z), io, mr, mw, irw, rd, m2r, rw, sa, sb, ez, ps, alu, done, ill};
  endfunction

  task automatic check();
    exp_t        e;
    logic [19:0] obs;
    obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, ext_zero, pc_src, alu_ctrl, instr_done, illegal_op};
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%05h expected=queued entry", obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%05h expected=%05h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic push_reset(string tag);
    exp_q.push_back('{tag, expv(ST_RST, 6'h00, 6'h00, 1'b0, 1'b1)});
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge after the last checked cycle
  task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, logic z,
                           int fetch_waits, int max_cycles);
    int sts[$];
    int n;
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < fetch_waits; i++) sts.push_back(ST_F);
    sts.push_back(ST_F);
    sts.push_back(ST_D);
    if (legal(op, fn)) begin
      case (op)
        6'h23:               begin sts.push_back(ST_MA); sts.push_back(ST_MR); sts.push_back(ST_MWB); end
        6'h2B:               begin sts.push_back(ST_MA); sts.push_back(ST_MWR); end
        6'h00:               begin sts.push_back(ST_RE); sts.push_back(ST_RW); end
        6'h08, 6'h0C, 6'h0D: begin sts.push_back(ST_IE); sts.push_back(ST_IW); end
        6'h04:               sts.push_back(ST_BR);
        default:             sts.push_back(ST_JP);
      endcase
    end
    n = (sts.size() < max_cycles) ? sts.size() : max_cycles;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{$sformatf("%s.c%0d", name, i + 1), expv(sts[i], op, fn, z, i >= fetch_waits)});
    for (int i = 0; i < n; i++) begin
      mem_ready = (i >= fetch_waits);
      #1;
      check();
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    zero      = 1'b0;
    repeat (2) @(negedge clk);
    push_reset("reset_idle");
    #1 check();
    opcode = 6'h02;
    push_reset("reset_op_j");
    #1 check();
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("r_add",   6'h00, 6'h20, 1'b0, 0, 99);
    run_instr("lw",      6'h23, 6'h00, 1'b0, 0, 99);
    run_instr("sw",      6'h2B, 6'h00, 1'b0, 0, 99);
    run_instr("beq_z1",  6'h04, 6'h00, 1'b1, 0, 99);
    run_instr("beq_z0",  6'h04, 6'h00, 1'b0, 0, 99);
    run_instr("ori",     6'h0D, 6'h00, 1'b0, 0, 99);
    run_instr("andi",    6'h0C, 6'h00, 1'b0, 0, 99);
    run_instr("addi",    6'h08, 6'h00, 1'b0, 0, 99);
    run_instr("r_sub",   6'h00, 6'h22, 1'b0, 0, 99);
    run_instr("r_and",   6'h00, 6'h24, 1'b0, 0, 99);
    run_instr("r_or",    6'h00, 6'h25, 1'b0, 0, 99);
    run_instr("r_slt",   6'h00, 6'h2A, 1'b0, 0, 99);
    run_instr("ill_op",  6'h3F, 6'h00, 1'b0, 0, 99);
    run_instr("ill_fn",  6'h00, 6'h27, 1'b0, 0, 99);
    run_instr("j",       6'h02, 6'h00, 1'b0, 0, 99);

    // Abort lw in MEM_RD: outputs must drop as soon as rst_n falls
    run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 0, 3);
    exp_q.push_back('{"lw_abort.mem_rd", expv(ST_MR, 6'h23, 6'h00, 1'b0, 1'b1)});
    #1 check();
    #1 rst_n = 1'b0;
    push_reset("abort_now");
    #1 check();
    @(negedge clk);
    push_reset("abort_held");
    #1 check();
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("after_abort_j", 6'h02, 6'h00, 1'b0, 0, 99);

`ifdef MIPS_MC_MEM_WAIT_EN
    run_instr("fetch_wait3", 6'h0D, 6'h00, 1'b0, 3, 99);
    run_instr("after_wait",  6'h00, 6'h20, 1'b0, 0, 99);
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
